i2c_init_seq: RTL and testbench

I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

---
 rtl/i2c_seq_pkg.sv | 30 +++
 rtl/i2c_seq_delay.sv | 29 ++
 rtl/i2c_init_seq.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared encodings for the I2C init sequencer: FSM states, table markers,
// controller register map and status bit positions.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, WR_CMD, RD_STAT, WAIT_RV, DELAY, DONE, ERR
  } state_t;

  localparam logic [15:0] END_WORD  = 16'hFFFF;
  localparam logic [7:0]  DELAY_REG = 8'hFE;

  localparam logic [1:0] CMD_ADDR  = 2'd0;
  localparam logic [1:0] STAT_ADDR = 2'd1;

  localparam int unsigned BUSY_BIT = 0;
  localparam int unsigned NACK_BIT = 1;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] val;
  } tbl_entry_t;

  // Command word written to the controller CMD register
  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] dev;
    tbl_entry_t entry;
  } cmd_word_t;

endpackage

// File: rtl/i2c_seq_delay.sv
// Down-counter for table delay entries: load a cycle count, expire_c pulses
// during the last counted cycle.
module i2c_seq_delay
  import i2c_seq_pkg::*;
#(
  parameter int unsigned CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire_c
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire_c = (cnt == CW'(1));

endmodule

// File: rtl/i2c_init_seq.sv
// Walks a register/value table and writes each entry to an Avalon-MM I2C
// controller, polling status. Define I2C_SEQ_RETRY_EN to retry NACKed entries.
module i2c_init_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int unsigned TBL_AW     = 8,
  parameter int unsigned DELAY_UNIT = 50000,
  parameter int unsigned RETRY_MAX  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic [1:0]        av_address,
  output logic              av_write,
  output logic              av_read,
  output logic [31:0]       av_writedata,
  input  logic [31:0]       av_readdata,
  input  logic              av_readdatavalid,
  input  logic              av_waitrequest
);

  localparam int unsigned DLY_W = $clog2(255 * DELAY_UNIT + 1);

  state_t              state, state_n;
  logic                busy_n, done_n, err_n;
  logic [TBL_AW-1:0]   tbl_addr_n;
  logic [1:0]          av_address_n;
  logic                av_write_n, av_read_n;
  logic [31:0]         av_writedata_n;
  logic                advance;
  logic                dly_load, dly_expire_c;
  logic [DLY_W-1:0]    dly_val;
  tbl_entry_t          entry;
  cmd_word_t           cmd_word;
  logic                unused_bits;

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RW-1:0] retry_cnt, retry_n;
  assign unused_bits = ^av_readdata[31:2];
`else
  assign unused_bits = ^{av_readdata[31:2], 32'(RETRY_MAX)};
`endif

  assign entry    = tbl_entry_t'(tbl_data);
  assign cmd_word = '{rsvd: 8'h00, dev: DEV_ADDR, entry: entry};

  i2c_seq_delay #(.CW(DLY_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .expire_c (dly_expire_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tbl_addr     <= '0;
      av_address   <= '0;
      av_write     <= 1'b0;
      av_read      <= 1'b0;
      av_writedata <= '0;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      state        <= state_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
      tbl_addr     <= tbl_addr_n;
      av_address   <= av_address_n;
      av_write     <= av_write_n;
      av_read      <= av_read_n;
      av_writedata <= av_writedata_n;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt    <= retry_n;
`endif
    end
  end

  // Next state; outputs are computed for the cycle after the edge
  always_comb begin
    state_n        = state;
    busy_n         = busy;
    done_n         = 1'b0;
    err_n          = err;
    tbl_addr_n     = tbl_addr;
    av_address_n   = av_address;
    av_write_n     = 1'b0;
    av_read_n      = 1'b0;
    av_writedata_n = av_writedata;
    advance        = 1'b0;
    dly_load       = 1'b0;
    dly_val        = '0;
`ifdef I2C_SEQ_RETRY_EN
    retry_n        = retry_cnt;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = FETCH;
          tbl_addr_n = '0;
          err_n      = 1'b0;
          busy_n     = 1'b1;
        end
      end
      FETCH: state_n = DECODE;
      DECODE: begin
        if (tbl_data == END_WORD) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else if (entry.reg_addr == DELAY_REG) begin
          if (entry.val == 8'h00) begin
            advance = 1'b1;
          end else begin
            dly_load = 1'b1;
            dly_val  = DLY_W'(entry.val) * DLY_W'(DELAY_UNIT);
            state_n  = DELAY;
          end
        end else begin
          state_n        = WR_CMD;
          av_write_n     = 1'b1;
          av_address_n   = CMD_ADDR;
          av_writedata_n = 32'(cmd_word);
`ifdef I2C_SEQ_RETRY_EN
          retry_n        = '0;
`endif
        end
      end
      WR_CMD: begin
        if (av_waitrequest) begin
          av_write_n = 1'b1;
        end else begin
          state_n      = RD_STAT;
          av_read_n    = 1'b1;
          av_address_n = STAT_ADDR;
        end
      end
      RD_STAT: begin
        if (av_waitrequest) begin
          av_read_n = 1'b1;
        end else begin
          state_n = WAIT_RV;
        end
      end
      WAIT_RV: begin
        if (av_readdatavalid) begin
          if (av_readdata[BUSY_BIT]) begin
            state_n   = RD_STAT;
            av_read_n = 1'b1;
          end else if (!av_readdata[NACK_BIT]) begin
            advance = 1'b1;
          end else begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_cnt < RW'(RETRY_MAX)) begin
              retry_n      = retry_cnt + RW'(1);
              state_n      = WR_CMD;
              av_write_n   = 1'b1;
              av_address_n = CMD_ADDR;
            end else begin
              state_n = ERR;
              err_n   = 1'b1;
              busy_n  = 1'b0;
            end
`else
            state_n = ERR;
            err_n   = 1'b1;
            busy_n  = 1'b0;
`endif
          end
        end
      end
      DELAY: begin
        if (dly_expire_c) advance = 1'b1;
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Step to the next entry; the last ROM address ends the table without wrapping
    if (advance) begin
      if (tbl_addr == '1) begin
        state_n = DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end else begin
        tbl_addr_n = tbl_addr + TBL_AW'(1);
        state_n    = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Table-driven bench for i2c_init_seq with an Avalon I2C controller model and
// a write-data scoreboard.
module tb_i2c_init_seq;

  localparam int          TBL_AW     = 3;
  localparam int          DELAY_UNIT = 10;
  localparam int          RETRY_MAX  = 3;
  localparam logic [7:0]  DEV        = 8'h42;
`ifdef I2C_SEQ_RETRY_EN
  localparam int NACK_WR = RETRY_MAX + 1;
`else
  localparam int NACK_WR = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, start;
  logic              busy, done, err;
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       tbl_data;
  logic [1:0]        av_address;
  logic              av_write, av_read;
  logic [31:0]       av_writedata, av_readdata;
  logic              av_readdatavalid, av_waitrequest;

  i2c_init_seq #(
    .DEV_ADDR(DEV), .TBL_AW(TBL_AW), .DELAY_UNIT(DELAY_UNIT), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .av_address(av_address),
    .av_write(av_write), .av_read(av_read), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .av_waitrequest(av_waitrequest)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [8];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller model state
  int          cyc = 0;
  int          wr_wait_left = 0, busy_first = 0, busy_left = 0, nack_left = 0;
  int          wr_count = 0, stall_cycles = 0, reads_since_wr = 0, last_rv_cyc = 0;
  logic [7:0]  nack_reg = 8'h00;
  bit          cur_nack = 0, rv_pend = 0, prev_wait = 0;
  logic [31:0] rv_data = '0, prev_data = '0;
  logic [1:0]  prev_addr = '0;
  int          reads_hist[$];
  int          gap_hist[$];
  logic [31:0] exp_q[$];

  // Slave responses are driven and DUT strobes observed on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      av_waitrequest   = 1'b0;
      av_readdatavalid = 1'b0;
      prev_wait        = 1'b0;
    end else begin
      if (rv_pend) begin
        av_readdatavalid = 1'b1;
        av_readdata      = rv_data;
        rv_pend          = 1'b0;
        if (!rv_data[0]) last_rv_cyc = cyc;
      end else begin
        av_readdatavalid = 1'b0;
        av_readdata      = 32'h0;
      end
      if (prev_wait) begin
        check("wr_hold_strobe", 32'(av_write), 32'd1);
        check("wr_hold_addr", 32'(av_address), 32'(prev_addr));
        check("wr_hold_data", av_writedata, prev_data);
      end
      prev_wait      = 1'b0;
      av_waitrequest = 1'b0;
      if (av_write || av_read) check("rw_exclusive", 32'(av_write & av_read), 32'd0);
      if (av_write) begin
        if (wr_wait_left > 0) begin
          av_waitrequest = 1'b1;
          wr_wait_left--;
          stall_cycles++;
          prev_wait = 1'b1;
          prev_addr = av_address;
          prev_data = av_writedata;
        end else begin
          check("wr_addr", 32'(av_address), 32'd0);
          if (exp_q.size() == 0) check("extra_write", av_writedata, 32'hXXXX_XXXX);
          else check("wr_data", av_writedata, exp_q.pop_front());
          reads_hist.push_back(reads_since_wr);
          gap_hist.push_back(cyc - last_rv_cyc);
          reads_since_wr = 0;
          wr_count++;
          busy_left = (wr_count == 1) ? busy_first : 0;
          cur_nack  = (av_writedata[15:8] == nack_reg) && (nack_left > 0);
        end
      end else if (av_read) begin
        check("rd_addr", 32'(av_address), 32'd1);
        check("one_outstanding", 32'(rv_pend), 32'd0);
        rv_pend = 1'b1;
        reads_since_wr++;
        if (busy_left > 0) begin
          busy_left--;
          rv_data = 32'hA5A5_0001;
        end else if (cur_nack) begin
          nack_left--;
          rv_data = 32'hA5A5_0002;
        end else begin
          rv_data = 32'hA5A5_0000;
        end
      end
    end
  end

  typedef struct {
    logic [7:0][15:0] tbl;
    int               ww;
    int               bf;
    logic [7:0]       nr;
    int               nc;
    int               nwr;
    bit               xerr;
    int               rd1;
    int               gap1;
    bit               poke;
  } vec_t;

  function automatic vec_t mkv(input logic [15:0] e0, e1, e2, e3, input int ww, bf,
                               input logic [7:0] nr, input int nc, nwr, input bit xerr,
                               input int rd1, gap1, input bit poke);
    vec_t v;
    v.tbl = {8{16'hFFFF}};
    v.tbl[0] = e0; v.tbl[1] = e1; v.tbl[2] = e2; v.tbl[3] = e3;
    v.ww = ww; v.bf = bf; v.nr = nr; v.nc = nc; v.nwr = nwr; v.xerr = xerr;
    v.rd1 = rd1; v.gap1 = gap1; v.poke = poke;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] w;
    bit stop, fin, got_done;
    for (int i = 0; i < 8; i++) rom[i] = v.tbl[i];
    wr_wait_left = v.ww; busy_first = v.bf; busy_left = 0;
    nack_reg = v.nr; nack_left = v.nc; cur_nack = 0;
    wr_count = 0; stall_cycles = 0; reads_since_wr = 0; last_rv_cyc = 0;
    reads_hist.delete(); gap_hist.delete(); exp_q.delete();
    // Expected command words, stopping at the end marker or a NACKed entry
    stop = 0;
    for (int i = 0; i < 8 && !stop; i++) begin
      w = v.tbl[i];
      if (w == 16'hFFFF) stop = 1;
      else if (w[15:8] != 8'hFE) begin
        if (v.nc > 0 && w[15:8] == v.nr) begin
          for (int k = 0; k < NACK_WR; k++) exp_q.push_back({8'h00, DEV, w});
          stop = 1;
        end else begin
          exp_q.push_back({8'h00, DEV, w});
        end
      end
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    fin = 0; got_done = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      start = v.poke && (c == 20);
      if (done) begin got_done = 1; fin = 1; end
      if (err) fin = 1;
    end
    start = 1'b0;
    check($sformatf("v%0d_finished", idx), 32'(fin), 32'd1);
    check($sformatf("v%0d_done", idx), 32'(got_done), 32'(!v.xerr));
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
    check($sformatf("v%0d_err", idx), 32'(err), 32'(v.xerr));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check($sformatf("v%0d_writes", idx), 32'(wr_count), 32'(v.nwr));
    check($sformatf("v%0d_pending", idx), 32'(exp_q.size()), 32'd0);
    if (v.ww > 0) check($sformatf("v%0d_stalls", idx), 32'(stall_cycles), 32'(v.ww));
    if (v.rd1 >= 0)
      check($sformatf("v%0d_reads_w1", idx), 32'(reads_hist.size() > 1 ? reads_hist[1] : -1), 32'(v.rd1));
    if (v.gap1 >= 0)
      check($sformatf("v%0d_gap_w1", idx), 32'(gap_hist.size() > 1 ? gap_hist[1] : -1), 32'(v.gap1));
  endtask

  vec_t vecs[7];

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0;
    av_readdata = '0; av_readdatavalid = 1'b0; av_waitrequest = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_tbl_addr", 32'(tbl_addr), 0);
    check("rst_av_write", 32'(av_write), 0);
    check("rst_av_read", 32'(av_read), 0);
    check("rst_av_address", 32'(av_address), 0);
    check("rst_av_writedata", av_writedata, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_strobes", 32'({av_write, av_read}), 0);

    // Gap of 35 = delay entry's 30 ticks + its own fetch/decode (2) + fetch/decode/issue of the next write (3)
    vecs[0] = mkv(16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 0, 0, 8'h00, 0, 2, 0, -1, -1, 0);
    vecs[1] = mkv(16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 5, 0, 8'h00, 0, 2, 0, -1, -1, 0);
    vecs[2] = mkv(16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 0, 3, 8'h00, 0, 2, 0, 4, -1, 0);
    vecs[3] = mkv(16'h1234, 16'h5678, 16'h9ABC, 16'hFFFF, 0, 0, 8'h56, 10, 1 + NACK_WR, 1, -1, -1, 0);
    vecs[4] = mkv(16'hFE00, 16'h1111, 16'hFFFF, 16'hFFFF, 0, 0, 8'h00, 0, 1, 0, -1, -1, 0);
    vecs[5] = mkv(16'h1234, 16'hFE03, 16'h5678, 16'hFFFF, 0, 0, 8'h00, 0, 2, 0, -1, 35, 1);
    vecs[6] = mkv(16'h0101, 16'h0202, 16'h0303, 16'h0404, 0, 0, 8'h00, 0, 8, 0, -1, -1, 0);
    vecs[6].tbl[4] = 16'h0505; vecs[6].tbl[5] = 16'h0606;
    vecs[6].tbl[6] = 16'h0707; vecs[6].tbl[7] = 16'h0808;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Reset while the status read response is outstanding
    for (int i = 0; i < 8; i++) rom[i] = vecs[0].tbl[i];
    wr_wait_left = 0; busy_first = 1000; busy_left = 0; nack_left = 0;
    wr_count = 0; exp_q.delete(); exp_q.push_back({8'h00, DEV, 16'h1234});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200 && wr_count == 0; c++) @(negedge clk);
    check("rstt_first_write", 32'(wr_count), 32'd1);
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk); #2;
      if (busy && !av_read && !av_write) ok = 1;
    end
    check("rstt_in_wait_rv", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstt_busy", 32'(busy), 0);
    check("rstt_done", 32'(done), 0);
    check("rstt_err", 32'(err), 0);
    check("rstt_tbl_addr", 32'(tbl_addr), 0);
    check("rstt_av_write", 32'(av_write), 0);
    check("rstt_av_read", 32'(av_read), 0);
    check("rstt_av_address", 32'(av_address), 0);
    check("rstt_av_writedata", av_writedata, 0);
    rst = 1'b0;
    rv_pend = 0; busy_left = 0; busy_first = 0;
    repeat (5) @(negedge clk);
    check("rstt_quiet", 32'({busy, av_write, av_read}), 0);
    run_vec(vecs[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
